// File: rtl/ysyx_201979054_div_pkg.sv
// ysyx_201979054_div_pkg: shared op/state encodings and sizing constants for the RV64M divider
package ysyx_201979054_div_pkg;
   typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} div_state_t;
   localparam int DIV_DATA_W = 64;
   localparam int CNT_W = $clog2(DIV_DATA_W + 1);
endpackage

// File: rtl/ysyx_201979054_div_core.sv
// ysyx_201979054_div_core: unsigned radix-2 restoring divider, one quotient bit per step
module ysyx_201979054_div_core
   import ysyx_201979054_div_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_W,
   parameter int CW = CNT_W
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic [CW-1:0]         count,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  done
);
   localparam int W = DATA_WIDTH;
   logic [W-1:0]  rem_q, quo_q, div_q;
   logic [CW-1:0] cnt_q;
   logic [W:0]    shifted, diff;

   // trial subtraction of the divisor from the partial remainder shifted by one bit
   always_comb begin
      shifted = {rem_q, quo_q[W-1]};
      diff = shifted - {1'b0, div_q};
   end

   // load operands, then shift-subtract-restore while the counter runs down
   always_ff @(posedge clk) begin
      if (arst) begin
         rem_q <= '0;
         quo_q <= '0;
         div_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         div_q <= divisor;
         cnt_q <= count;
      end else if (step && cnt_q != '0) begin
         rem_q <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
         quo_q <= {quo_q[W-2:0], ~diff[W]};
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign quotient = quo_q;
   assign remainder = rem_q;
   assign done = cnt_q == CW'(1);
endmodule

// File: rtl/ysyx_201979054_div_unit.sv
// ysyx_201979054_div_unit: multi-cycle DIV/DIVU/REM/REMU unit; DIV_WORD_OPS_EN adds the *W forms via i_word
module ysyx_201979054_div_unit
   import ysyx_201979054_div_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_W
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  i_start,
   input  logic [1:0]            i_op,
`ifdef DIV_WORD_OPS_EN
   input  logic                  i_word,
`endif
   input  logic [DATA_WIDTH-1:0] i_dividend,
   input  logic [DATA_WIDTH-1:0] i_divisor,
   input  logic                  i_kill,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result
);
   localparam int W = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
   div_state_t    state, state_nx;
   div_op_t       op_in, op_q;
   logic          sgn, sa, sb, div0_in, ovf_in, accept, last;
   logic          neg_q, neg_r, div0_q, ovf_q;
   logic [W-1:0]  a_ext, b_ext, abs_a, abs_b, core_a, a_q, quo, rem;
   logic [W-1:0]  q_fix, r_fix, res_raw, res_fix, res_q;
   logic [CW-1:0] core_cnt;
`ifdef DIV_WORD_OPS_EN
   logic          word_q;
`endif

   // extend operands, take magnitudes and signs, and spot the special cases at start
   always_comb begin
      op_in = div_op_t'(i_op);
      sgn = op_in == DIV || op_in == REM;
`ifdef DIV_WORD_OPS_EN
      a_ext = i_word ? (sgn ? {{(W-32){i_dividend[31]}}, i_dividend[31:0]} : {{(W-32){1'b0}}, i_dividend[31:0]}) : i_dividend;
      b_ext = i_word ? (sgn ? {{(W-32){i_divisor[31]}}, i_divisor[31:0]} : {{(W-32){1'b0}}, i_divisor[31:0]}) : i_divisor;
      div0_in = i_word ? (i_divisor[31:0] == 32'd0) : (i_divisor == '0);
      ovf_in = sgn && (i_word ? (i_dividend[31:0] == 32'h8000_0000 && i_divisor[31:0] == 32'hFFFF_FFFF)
                              : (i_dividend == MIN && i_divisor == '1));
      core_cnt = i_word ? CW'(32) : CW'(W);
`else
      a_ext = i_dividend;
      b_ext = i_divisor;
      div0_in = i_divisor == '0;
      ovf_in = sgn && i_dividend == MIN && i_divisor == '1;
      core_cnt = CW'(W);
`endif
      sa = sgn && a_ext[W-1];
      sb = sgn && b_ext[W-1];
      abs_a = sa ? -a_ext : a_ext;
      abs_b = sb ? -b_ext : b_ext;
`ifdef DIV_WORD_OPS_EN
      core_a = i_word ? abs_a << 32 : abs_a;
`else
      core_a = abs_a;
`endif
   end

   // state register
   always_ff @(posedge clk) begin
      if (arst) state <= IDLE;
      else state <= state_nx;
   end

   // next state, request acceptance and handshake outputs; a kill suppresses the done pulse
   always_comb begin
      state_nx = state;
      accept = 1'b0;
      o_done = 1'b0;
      o_busy = state != IDLE;
      if (state == IDLE) begin
         accept = i_start && !i_kill;
         state_nx = accept ? ((div0_in || ovf_in) ? DONE : CALC) : IDLE;
      end else if (state == CALC) begin
         state_nx = i_kill ? IDLE : (last ? DONE : CALC);
      end else begin
         o_done = !i_kill;
         state_nx = IDLE;
      end
   end

   // capture operand context on accept; commit the result when the done pulse fires
   always_ff @(posedge clk) begin
      if (arst) begin
         op_q <= DIV;
         a_q <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0_q <= 1'b0;
         ovf_q <= 1'b0;
         res_q <= '0;
`ifdef DIV_WORD_OPS_EN
         word_q <= 1'b0;
`endif
      end else begin
         if (accept) begin
            op_q <= op_in;
            a_q <= a_ext;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            div0_q <= div0_in;
            ovf_q <= ovf_in;
`ifdef DIV_WORD_OPS_EN
            word_q <= i_word;
`endif
         end
         if (o_done) res_q <= res_fix;
      end
   end

   // sign fix-up, special-case override and result selection; the held value shows otherwise
   always_comb begin
      q_fix = div0_q ? '1 : (ovf_q ? a_q : (neg_q ? -quo : quo));
      r_fix = div0_q ? a_q : (ovf_q ? '0 : (neg_r ? -rem : rem));
      res_raw = (op_q == REM || op_q == REMU) ? r_fix : q_fix;
`ifdef DIV_WORD_OPS_EN
      res_fix = word_q ? {{(W-32){res_raw[31]}}, res_raw[31:0]} : res_raw;
`else
      res_fix = res_raw;
`endif
      o_result = o_done ? res_fix : res_q;
   end

   ysyx_201979054_div_core #(.DATA_WIDTH(W), .CW(CW)) u_core (
      .clk       (clk),
      .arst      (arst),
      .load      (accept),
      .step      (state == CALC),
      .dividend  (core_a),
      .divisor   (abs_b),
      .count     (core_cnt),
      .quotient  (quo),
      .remainder (rem),
      .done      (last)
   );
endmodule

// File: tb/tb_ysyx_201979054_div_unit.sv
// tb_ysyx_201979054_div_unit: directed vectors plus a cycle-by-cycle arithmetic reference model
module tb_ysyx_201979054_div_unit;
   localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
   logic        clk = 1'b0, arst = 1'b1, i_start = 1'b0, i_kill = 1'b0, i_word = 1'b0;
   logic [1:0]  i_op = 2'b00;
   logic [63:0] i_dividend = '0, i_divisor = '0;
   logic        o_busy, o_done;
   logic [63:0] o_result;
   int          errors = 0, checks = 0;
   logic        m_valid = 1'b0, m_busy = 1'b0;
   int          m_left = 0;
   logic [63:0] m_pend = '0, m_res = '0;
   logic        exp_done;
   logic [63:0] exp_res;

   always #5 clk = ~clk;

   ysyx_201979054_div_unit dut (
      .clk        (clk),
      .arst       (arst),
      .i_start    (i_start),
      .i_op       (i_op),
`ifdef DIV_WORD_OPS_EN
      .i_word     (i_word),
`endif
      .i_dividend (i_dividend),
      .i_divisor  (i_divisor),
      .i_kill     (i_kill),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_result   (o_result)
   );

   function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic w);
      longint sx, sy;
      longint unsigned ux, uy;
      int xs, ys;
      int unsigned xu, yu;
      logic [63:0] q, r;
      logic [31:0] q32, r32;
      if (w) begin
         xu = a[31:0]; yu = b[31:0]; xs = a[31:0]; ys = b[31:0];
         if (yu == 0) begin q32 = '1; r32 = xu; end
         else if (!op[0] && xu == 32'h8000_0000 && ys == -1) begin q32 = xu; r32 = '0; end
         else if (!op[0]) begin q32 = xs / ys; r32 = xs % ys; end
         else begin q32 = xu / yu; r32 = xu % yu; end
         return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      end
      ux = a; uy = b; sx = a; sy = b;
      if (uy == 0) begin q = '1; r = ux; end
      else if (!op[0] && ux == MIN && sy == -1) begin q = ux; r = '0; end
      else if (!op[0]) begin q = sx / sy; r = sx % sy; end
      else begin q = ux / uy; r = ux % uy; end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic w);
      logic special;
      special = (w ? b[31:0] == 32'd0 : b == 64'd0) ||
                (!op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN && b == '1)));
      return special ? 1 : (w ? 33 : 65);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model: accepted request completes after its latency unless killed or reset
   always @(posedge clk) begin
      if (arst) begin
         m_valid <= 1'b1;
         m_busy <= 1'b0;
         m_left <= 0;
         m_pend <= '0;
         m_res <= '0;
      end else if (!m_busy) begin
         if (i_start && !i_kill) begin
            m_busy <= 1'b1;
            m_pend <= ref_res(i_op, i_dividend, i_divisor, i_word);
            m_left <= ref_lat(i_op, i_dividend, i_divisor, i_word) - 1;
         end
      end else if (i_kill) begin
         m_busy <= 1'b0;
      end else if (m_left == 0) begin
         m_busy <= 1'b0;
         m_res <= m_pend;
      end else begin
         m_left <= m_left - 1;
      end
   end

   assign exp_done = m_busy && m_left == 0 && !i_kill;
   assign exp_res = exp_done ? m_pend : m_res;

   // compare every cycle once the model has seen reset
   always @(negedge clk) begin
      if (m_valid) begin
         check("busy", 64'(o_busy), 64'(m_busy));
         check("done", 64'(o_done), 64'(exp_done));
         check("result", o_result, exp_res);
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic w);
      @(posedge clk); #1;
      i_op = op; i_dividend = a; i_divisor = b; i_word = w; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int dc, output logic [63:0] r);
      dc = -1;
      r = '0;
      for (int c = c0; c <= 100 && dc < 0; c++) begin
         @(negedge clk);
         if (o_done) begin
            dc = c;
            r = o_result;
         end else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic run(input string name, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic w, input int ec, input logic [63:0] er);
      int dc;
      logic [63:0] r;
      start_op(op, a, b, w);
      wait_done(1, dc, r);
      check({name, "_cycle"}, 64'(dc), 64'(ec));
      check({name, "_result"}, r, er);
   endtask

   initial begin
      int dc;
      logic [63:0] r;
      logic seen;
      check("model_div", ref_res(2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0), 64'hFFFF_FFFF_FFFF_FFFD);
      check("model_remu", ref_res(2'b11, 64'd100, 64'd7, 1'b0), 64'd2);
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;
      @(negedge clk);
      check("reset_busy", 64'(o_busy), 64'd0);
      check("reset_done", 64'(o_done), 64'd0);
      check("reset_result", o_result, 64'd0);
      run("divu", 2'b01, 64'd100, 64'd7, 1'b0, 65, 64'd14);
      run("remu", 2'b11, 64'd100, 64'd7, 1'b0, 65, 64'd2);
      run("div_neg", 2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 65, 64'hFFFF_FFFF_FFFF_FFFD);
      run("rem_neg", 2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 65, 64'hFFFF_FFFF_FFFF_FFFF);
      run("div_negdiv", 2'b00, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 65, 64'hFFFF_FFFF_FFFF_FFF2);
      run("rem_negdiv", 2'b10, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 65, 64'd2);
      run("divu_zero", 2'b01, 64'd5, 64'd0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      run("rem_zero", 2'b10, 64'd5, 64'd0, 1'b0, 1, 64'd5);
      run("div_ovf", 2'b00, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, MIN);
      run("rem_ovf", 2'b10, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 64'd0);
      start_op(2'b01, 64'd1000, 64'd10, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      i_dividend = 64'd9; i_divisor = 64'd3; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done(11, dc, r);
      check("ignore_cycle", 64'(dc), 64'd65);
      check("ignore_result", r, 64'd100);
      start_op(2'b00, 64'd77, 64'd7, 1'b0);
      repeat (19) @(posedge clk);
      #1 i_kill = 1'b1;
      @(posedge clk); #1;
      i_kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 64'(o_busy), 64'd0);
      check("kill_result", o_result, 64'd100);
      seen = 1'b0;
      repeat (70) begin
         @(negedge clk);
         seen = seen | o_done;
      end
      check("kill_no_done", 64'(seen), 64'd0);
      run("div_after_kill", 2'b00, 64'd77, 64'd7, 1'b0, 65, 64'd11);
      start_op(2'b01, 64'd100, 64'd7, 1'b0);
      repeat (29) @(posedge clk);
      #1 arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_result", o_result, 64'd0);
      @(posedge clk); #1;
      i_op = 2'b01; i_dividend = 64'd50; i_divisor = 64'd5; i_start = 1'b1; i_kill = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_kill = 1'b0;
      @(negedge clk);
      check("drop_busy", 64'(o_busy), 64'd0);
      run("remu_after", 2'b11, 64'd100, 64'd7, 1'b0, 65, 64'd2);
`ifdef DIV_WORD_OPS_EN
      run("divw", 2'b00, 64'h1_FFFF_FFF8, 64'd2, 1'b1, 33, 64'hFFFF_FFFF_FFFF_FFFC);
      run("remuw_zero", 2'b11, 64'h1_8000_0001, 64'd0, 1'b1, 1, 64'hFFFF_FFFF_8000_0001);
      run("divuw", 2'b01, 64'hFFFF_0000_0000_0064, 64'd7, 1'b1, 33, 64'd14);
`endif
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
